// File: rtl/ysyx_22050019_ifu_fetch_if.sv
// Purpose: read-only memory port between the fetch unit and instruction memory.
// Latency: none; this is wiring only.
// Backpressure: an address is held by ar_valid_o until ar_ready_i; data is held by r_valid_i until r_ready_o.
// Ports: ar_valid_o/ar_addr_o/ar_ready_i form the address channel.
//        r_valid_i/r_data_i/r_ready_o form the data channel.
//        Suffixes are named from the fetch unit's point of view.
interface ysyx_22050019_ifu_fetch_if;
    logic        ar_valid_o;
    logic [63:0] ar_addr_o;
    logic        ar_ready_i;
    logic        r_valid_i;
    logic [63:0] r_data_i;
    logic        r_ready_o;

    modport master (
        output ar_valid_o, ar_addr_o, r_ready_o,
        input  ar_ready_i, r_valid_i, r_data_i
    );

    modport slave (
        input  ar_valid_o, ar_addr_o, r_ready_o,
        output ar_ready_i, r_valid_i, r_data_i
    );
endinterface

// File: rtl/ysyx_22050019_ifu_fetch.sv
// Purpose: instruction-fetch front end; owns the fetch PC and issues one 64-bit read per instruction.
// Latency: commite_o is raised 2 cycles after REQ when memory has zero wait states; throughput is 1 instruction every 3 cycles.
// Backpressure: the instruction is held in HOLD while if_id_stall_i=1; the address is held in REQ until ar_ready_i.
// Ports: clk, rst_n (synchronous, active-high despite the name)
//        if_id_stall_i, jump_en_i, jump_pc_i : control from later pipeline stages
//        mem : memory read port (master side)
//        pc_o, inst_o, commite_o, ifu_ok_o : producer side of the IF/ID register
module ysyx_22050019_ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             if_id_stall_i,
    input  logic                             jump_en_i,
    input  logic [63:0]                      jump_pc_i,
    ysyx_22050019_ifu_fetch_if.master        mem,
    output logic [63:0]                      pc_o,
    output logic [31:0]                      inst_o,
    output logic                             commite_o,
    output logic                             ifu_ok_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic [31:0] inst_q, inst_d;
    logic        drop_q, drop_d;

    logic [63:0] jump_target;
    logic [31:0] r_word;
    logic        unused_low_bits;

    // Redirect targets are word-aligned; the low two bits are ignored.
    assign jump_target = {jump_pc_i[63:2], 2'b00};
    // Pick the 32-bit half of the 64-bit beat that holds the requested word.
    assign r_word = req_addr_q[2] ? mem.r_data_i[63:32] : mem.r_data_i[31:0];
    assign unused_low_bits = ^{jump_pc_i[1:0], req_addr_q[1:0]};

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= 64'd0;
            inst_q     <= 32'd0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inst_q     <= inst_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        inst_d     = inst_q;
        drop_d     = drop_q;

        case (state_q)
            S_IDLE: begin
                if (jump_en_i) begin
                    pc_d       = jump_target;
                    req_addr_d = jump_target;
                end else begin
                    req_addr_d = pc_q;
                end
                state_d = S_REQ;
            end
            S_REQ: begin
                // req_addr_q stays fixed here so the presented address never changes.
                // A redirect only retargets pc and marks the in-flight read for discard.
                if (jump_en_i) begin
                    pc_d   = jump_target;
                    drop_d = 1'b1;
                end
                if (mem.ar_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.r_valid_i) begin
                    if (jump_en_i) begin
                        // The beat arriving with the redirect is stale. Refetch the target.
                        pc_d       = jump_target;
                        req_addr_d = jump_target;
                        drop_d     = 1'b0;
                        state_d    = S_REQ;
                    end else if (drop_q) begin
                        req_addr_d = pc_q;
                        drop_d     = 1'b0;
                        state_d    = S_REQ;
                    end else begin
                        inst_d  = r_word;
                        state_d = S_HOLD;
                    end
                end else if (jump_en_i) begin
                    pc_d   = jump_target;
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                // A redirect kills the held instruction even while IF/ID is stalled.
                if (jump_en_i) begin
                    pc_d       = jump_target;
                    req_addr_d = jump_target;
                    state_d    = S_REQ;
                end else if (!if_id_stall_i) begin
                    pc_d       = pc_q + PC_STEP;
                    req_addr_d = pc_q + PC_STEP;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem.ar_valid_o = (state_q == S_REQ);
    assign mem.ar_addr_o  = (state_q == S_REQ) ? {req_addr_q[63:3], 3'b000} : 64'd0;
    assign mem.r_ready_o  = (state_q == S_WAIT);

    assign pc_o      = pc_q;
    assign inst_o    = (state_q == S_HOLD) ? inst_q : 32'd0;
    assign ifu_ok_o  = (state_q == S_HOLD);
    assign commite_o = (state_q == S_HOLD) && !jump_en_i;

endmodule

// File: tb/tb_ysyx_22050019_ifu_fetch.sv
module tb_ysyx_22050019_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_id_stall_i;
    logic        jump_en_i;
    logic [63:0] jump_pc_i;
    logic [63:0] pc_o;
    logic [31:0] inst_o;
    logic        commite_o;
    logic        ifu_ok_o;

    ysyx_22050019_ifu_fetch_if mem ();

    ysyx_22050019_ifu_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_id_stall_i (if_id_stall_i),
        .jump_en_i     (jump_en_i),
        .jump_pc_i     (jump_pc_i),
        .mem           (mem),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .commite_o     (commite_o),
        .ifu_ok_o      (ifu_ok_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        jump;
        logic [63:0] jpc;
        logic        ar_rdy;
        logic        r_vld;
        logic [63:0] rdat;
        logic        e_arv;
        logic [63:0] e_addr;
        logic        e_rr;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        logic        e_com;
        logic        e_ok;
    } vec_t;

    localparam logic [63:0] D0 = 64'h0000_0013_0000_0093;
    localparam logic [63:0] D1 = 64'hAAAA_BBBB_1111_2222;
    localparam int NV = 21;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NV];

    function automatic vec_t mk(logic stall, logic jump, logic [63:0] jpc, logic ar_rdy,
                                logic r_vld, logic [63:0] rdat, logic e_arv, logic [63:0] e_addr,
                                logic e_rr, logic [63:0] e_pc, logic [31:0] e_inst,
                                logic e_com, logic e_ok);
        vec_t v;
        v.stall = stall;   v.jump = jump;     v.jpc = jpc;
        v.ar_rdy = ar_rdy; v.r_vld = r_vld;   v.rdat = rdat;
        v.e_arv = e_arv;   v.e_addr = e_addr; v.e_rr = e_rr;
        v.e_pc = e_pc;     v.e_inst = e_inst; v.e_com = e_com; v.e_ok = e_ok;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_all(string tag, logic e_arv, logic [63:0] e_addr, logic e_rr,
                             logic [63:0] e_pc, logic [31:0] e_inst, logic e_com, logic e_ok);
        chk({tag, " ar_valid"}, {63'd0, mem.ar_valid_o}, {63'd0, e_arv});
        chk({tag, " ar_addr"},  mem.ar_addr_o, e_addr);
        chk({tag, " r_ready"},  {63'd0, mem.r_ready_o}, {63'd0, e_rr});
        chk({tag, " pc"},       pc_o, e_pc);
        chk({tag, " inst"},     {32'd0, inst_o}, {32'd0, e_inst});
        chk({tag, " commite"},  {63'd0, commite_o}, {63'd0, e_com});
        chk({tag, " ifu_ok"},   {63'd0, ifu_ok_o}, {63'd0, e_ok});
        chk({tag, " excl"},     {63'd0, mem.ar_valid_o & mem.r_ready_o}, 64'd0);
    endtask

    task automatic drive(logic stall, logic jump, logic [63:0] jpc, logic ar_rdy,
                         logic r_vld, logic [63:0] rdat);
        if_id_stall_i  = stall;
        jump_en_i      = jump;
        jump_pc_i      = jpc;
        mem.ar_ready_i = ar_rdy;
        mem.r_valid_i  = r_vld;
        mem.r_data_i   = rdat;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        //             stall jump jpc            ar r  rdat | arv addr           rr pc             inst           com ok
        vecs[0]  = mk(0, 0, 64'd0,          1, 0, 64'd0, 1, 64'h8000_0000, 0, 64'h8000_0000, 32'h0,         0, 0);
        vecs[1]  = mk(0, 0, 64'd0,          0, 1, D0,    0, 64'd0,         1, 64'h8000_0000, 32'h0,         0, 0);
        vecs[2]  = mk(0, 0, 64'd0,          0, 0, 64'd0, 0, 64'd0,         0, 64'h8000_0000, 32'h0000_0093, 1, 1);
        vecs[3]  = mk(0, 0, 64'd0,          1, 0, 64'd0, 1, 64'h8000_0000, 0, 64'h8000_0004, 32'h0,         0, 0);
        vecs[4]  = mk(0, 0, 64'd0,          0, 1, D0,    0, 64'd0,         1, 64'h8000_0004, 32'h0,         0, 0);
        vecs[5]  = mk(0, 0, 64'd0,          0, 0, 64'd0, 0, 64'd0,         0, 64'h8000_0004, 32'h0000_0013, 1, 1);
        vecs[6]  = mk(0, 0, 64'd0,          0, 0, 64'd0, 1, 64'h8000_0008, 0, 64'h8000_0008, 32'h0,         0, 0);
        vecs[7]  = mk(0, 1, 64'h8000_0180,  0, 0, 64'd0, 1, 64'h8000_0008, 0, 64'h8000_0008, 32'h0,         0, 0);
        vecs[8]  = mk(0, 1, 64'h8000_0100,  0, 0, 64'd0, 1, 64'h8000_0008, 0, 64'h8000_0180, 32'h0,         0, 0);
        vecs[9]  = mk(0, 0, 64'd0,          0, 0, 64'd0, 1, 64'h8000_0008, 0, 64'h8000_0100, 32'h0,         0, 0);
        vecs[10] = mk(0, 0, 64'd0,          1, 0, 64'd0, 1, 64'h8000_0008, 0, 64'h8000_0100, 32'h0,         0, 0);
        vecs[11] = mk(0, 0, 64'd0,          0, 0, 64'd0, 0, 64'd0,         1, 64'h8000_0100, 32'h0,         0, 0);
        vecs[12] = mk(0, 0, 64'd0,          0, 1, D0,    0, 64'd0,         1, 64'h8000_0100, 32'h0,         0, 0);
        vecs[13] = mk(0, 0, 64'd0,          1, 0, 64'd0, 1, 64'h8000_0100, 0, 64'h8000_0100, 32'h0,         0, 0);
        vecs[14] = mk(0, 0, 64'd0,          0, 1, D1,    0, 64'd0,         1, 64'h8000_0100, 32'h0,         0, 0);
        vecs[15] = mk(1, 1, 64'h8000_0203,  0, 0, 64'd0, 0, 64'd0,         0, 64'h8000_0100, 32'h1111_2222, 0, 1);
        vecs[16] = mk(0, 0, 64'd0,          1, 0, 64'd0, 1, 64'h8000_0200, 0, 64'h8000_0200, 32'h0,         0, 0);
        vecs[17] = mk(0, 1, 64'h8000_0304,  0, 1, D0,    0, 64'd0,         1, 64'h8000_0200, 32'h0,         0, 0);
        vecs[18] = mk(0, 0, 64'd0,          1, 0, 64'd0, 1, 64'h8000_0300, 0, 64'h8000_0304, 32'h0,         0, 0);
        vecs[19] = mk(0, 0, 64'd0,          0, 1, D0,    0, 64'd0,         1, 64'h8000_0304, 32'h0,         0, 0);
        vecs[20] = mk(1, 0, 64'd0,          0, 0, 64'd0, 0, 64'd0,         0, 64'h8000_0304, 32'h0000_0013, 1, 1);

        // Reset, then one idle cycle.
        rst_n = 1'b1;
        drive(0, 0, 64'd0, 0, 0, 64'd0);
        next_cycle();
        @(negedge clk);
        check_all("reset", 0, 64'd0, 0, 64'h8000_0000, 32'h0, 0, 0);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        check_all("idle", 0, 64'd0, 0, 64'h8000_0000, 32'h0, 0, 0);
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].jump, vecs[i].jpc, vecs[i].ar_rdy, vecs[i].r_vld, vecs[i].rdat);
            @(negedge clk);
            check_all($sformatf("row%0d", i), vecs[i].e_arv, vecs[i].e_addr, vecs[i].e_rr,
                      vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_com, vecs[i].e_ok);
            next_cycle();
        end

        // Five further stalled cycles in HOLD: everything must stay frozen.
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 64'd0, 0, 0, 64'd0);
            @(negedge clk);
            check_all($sformatf("stall%0d", k), 0, 64'd0, 0, 64'h8000_0304, 32'h0000_0013, 1, 1);
            next_cycle();
        end

        // Release: the instruction is handed off and the PC advances exactly once.
        drive(0, 0, 64'd0, 0, 0, 64'd0);
        @(negedge clk);
        check_all("release", 0, 64'd0, 0, 64'h8000_0304, 32'h0000_0013, 1, 1);
        next_cycle();
        drive(0, 0, 64'd0, 1, 0, 64'd0);
        @(negedge clk);
        check_all("advance", 1, 64'h8000_0308, 0, 64'h8000_0308, 32'h0, 0, 0);
        next_cycle();

        // Reset while waiting for data abandons the read.
        drive(0, 0, 64'd0, 0, 0, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("wait_pre_rst", 0, 64'd0, 1, 64'h8000_0308, 32'h0, 0, 0);
        next_cycle();
        rst_n = 1'b0;
        drive(0, 0, 64'd0, 0, 1, D1);
        @(negedge clk);
        check_all("rst_in_wait", 0, 64'd0, 0, 64'h8000_0000, 32'h0, 0, 0);
        next_cycle();

        // The stray beat in IDLE was ignored: a clean fetch from RESET_PC follows.
        drive(0, 0, 64'd0, 1, 0, 64'd0);
        @(negedge clk);
        check_all("refetch_req", 1, 64'h8000_0000, 0, 64'h8000_0000, 32'h0, 0, 0);
        next_cycle();
        drive(0, 0, 64'd0, 0, 1, D0);
        @(negedge clk);
        check_all("refetch_wait", 0, 64'd0, 1, 64'h8000_0000, 32'h0, 0, 0);
        next_cycle();
        drive(1, 0, 64'd0, 0, 0, 64'd0);
        @(negedge clk);
        check_all("refetch_hold", 0, 64'd0, 0, 64'h8000_0000, 32'h0000_0093, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_ifu_fetch.md
Name: ysyx_22050019_ifu_fetch

Overview:
- Instruction-fetch front end. Owns the architectural fetch PC and issues one AXI-style read per instruction on a 64-bit memory port.
- Presents each fetched instruction, with a valid (commite) flag, to the IF/ID pipeline register. This block is the producer side of that interface: it drives the pc/inst/commite/ifu_ok inputs of IF/ID.
- Honours the IF/ID stall and accepts branch/jump redirects from later stages.

Parameters:
- RESET_PC, 64'h8000_0000, first fetch address after reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset. One clock; reset is synchronous and active-high. The port is named rst_n as the codebase does, and asserted means rst_n==1.
- if_id_stall_i  input  1  IF/ID cannot accept this cycle.
- jump_en_i  input  1  redirect request (single-cycle pulse).
- jump_pc_i  input  64  redirect target.
- ar_valid_o  output  1  read address valid.
- ar_addr_o  output  64  read address; 8-byte aligned, bits [2:0]=0.
- ar_ready_i  input  1  read address accepted.
- r_valid_i  input  1  read data valid.
- r_data_i  input  64  read data.
- r_ready_o  output  1  ready for read data.
- pc_o  output  64  PC of the presented instruction.
- inst_o  output  32  presented instruction.
- commite_o  output  1  pc_o/inst_o are a valid instruction this cycle.
- ifu_ok_o  output  1  fetch complete; the instruction is held awaiting IF/ID.

Behaviour:
- States: IDLE, REQ, WAIT, HOLD. Registers: pc, req_addr, inst, drop.
- Reset (rst_n==1 at posedge, priority over everything):
  - state=IDLE, pc=RESET_PC, inst=0, drop=0.
  - All outputs 0 except pc_o=RESET_PC.
  - Reset mid-transaction abandons the transaction. The memory side is reset in the same cycle.
- IDLE: next cycle goes to REQ with req_addr=pc.
- REQ:
  - ar_valid_o=1, ar_addr_o={req_addr[63:3],3'b0}.
  - ar_addr_o stays stable until ar_ready_i. The address is never withdrawn.
  - On ar_ready_i, go to WAIT.
- WAIT:
  - r_ready_o=1.
  - On r_valid_i with drop=0: inst = req_addr[2] ? r_data_i[63:32] : r_data_i[31:0], then go to HOLD.
  - On r_valid_i with drop=1: discard the data, clear drop, set req_addr=pc, go to REQ.
- HOLD:
  - ifu_ok_o=1, commite_o = ~jump_en_i (combinational), pc_o=pc, inst_o=inst.
  - If if_id_stall_i=1 and no redirect: stay, holding all outputs.
  - If if_id_stall_i=0 and no redirect: handoff. Set pc=pc+PC_STEP (64-bit wrap), req_addr to the same value, go to REQ.
- Outside HOLD: commite_o=0, ifu_ok_o=0, inst_o=0, pc_o=pc.
- Redirect (jump_en_i=1), with target {jump_pc_i[63:2],2'b00}:
  - IDLE: pc=target.
  - REQ or WAIT: pc=target and drop=1. The in-flight read completes on the bus and its data is discarded.
  - Redirect in the same cycle as the r_valid_i beat: that beat is discarded. Next state is REQ with req_addr=target, drop=0.
  - HOLD: pc=target, the held instruction is killed, go to REQ with req_addr=target. This applies regardless of if_id_stall_i.
  - Multiple redirects before refetch: the last one wins.
- Latency: IDLE→REQ takes 1 cycle. With ar_ready_i and r_valid_i both high immediately, REQ→WAIT→HOLD gives commite_o 2 cycles after entering REQ. Steady-state throughput is 1 instruction per 3 cycles.
- At most one outstanding read at any time. ar_valid_o and r_ready_o are never high together.

Test Plan:
- Reset then zero-wait memory returning 64'h0000_0013_0000_0093 at 0x8000_0000:
  - ar_addr_o=0x8000_0000; HOLD shows inst_o=0x0000_0093, pc_o=0x8000_0000, commite_o=1.
  - Next fetch addresses 0x8000_0000 with pc=0x8000_0004 and yields inst_o=0x0000_0013.
- Stall: hold if_id_stall_i=1 for 5 cycles in HOLD.
  - pc_o, inst_o, commite_o=1, ifu_ok_o=1 stay constant for all 5 cycles; ar_valid_o=0.
  - Release → exactly one advance to pc+4.
- Address backpressure: ar_ready_i low for 4 cycles → ar_valid_o=1 and ar_addr_o unchanged throughout. A redirect to 0x8000_0100 during this window sets drop. The old read completes and is discarded; next ar_addr_o=0x8000_0100.
- Redirect in HOLD with jump_pc_i=0x8000_0203 → commite_o=0 that cycle; next ar_addr_o=0x8000_0200, pc_o=0x8000_0200.
- Redirect coincident with r_valid_i → no HOLD entry and no commite_o pulse for the old address; next REQ targets the jump address.
- Reset asserted in WAIT → next cycle state IDLE, all outputs 0, pc_o=0x8000_0000; a stray r_valid_i in IDLE is ignored.
